// File: rtl/seg7_scan_display_if.sv
// Display bus between the stopwatch side (master) and the scan driver (slave):
// BCD digits and display controls in, active-low segment/anode drive out.
interface seg7_scan_display_if;
  logic [15:0] digits_bcd;
  logic        freeze;
  logic        blank_leading;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  modport master (output digits_bcd, freeze, blank_leading, input seg, dp, an);
  modport slave  (input digits_bcd, freeze, blank_leading, output seg, dp, an);
endinterface

// File: rtl/seg7_scan_display.sv
// Four-digit common-anode seven-segment scanner. The BCD input is captured once
// per frame, so a frame never mixes two values. It supports freeze (lap hold),
// leading-zero blanking and a dash for non-BCD codes. All outputs are registered.
module seg7_scan_display #(
  parameter int         CLK_FREQ   = 100_000_000,
  parameter int         REFRESH_HZ = 250,
  parameter logic [3:0] DP_MASK    = 4'b0000
) (
  input  logic               clk,
  input  logic               init_regs,
  seg7_scan_display_if.slave bus
);
  localparam int DWELL_RAW = CLK_FREQ / (4 * REFRESH_HZ);
  localparam int DWELL     = (DWELL_RAW < 1) ? 1 : DWELL_RAW;
  localparam int DW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic          primed_q, primed_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          wrap, frame_end, load, blank;
  logic [3:0]    cur;
  logic [3:0]    zero;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111; // dash for A..F
    endcase
    return s;
  endfunction

  // Scan counters and snapshot: load on the first unfrozen edge after reset, then only at frame boundaries.
  always_comb begin
    wrap      = (dwell_q == DWELL_LAST);
    frame_end = wrap && (idx_q == 2'd3);
    load      = !bus.freeze && (!primed_q || frame_end);
    dwell_d   = wrap ? '0 : dwell_q + 1'b1;
    idx_d     = wrap ? idx_q + 2'd1 : idx_q;
    disp_d    = load ? bus.digits_bcd : disp_q;
    primed_d  = primed_q | load;
  end

  // Output decode for the current slot. The display stays dark until the first snapshot.
  always_comb begin
    for (int i = 0; i < 4; i++) zero[i] = (disp_q[i*4 +: 4] == 4'd0);
    unique case (idx_q)
      2'd0:    cur = disp_q[3:0];
      2'd1:    cur = disp_q[7:4];
      2'd2:    cur = disp_q[11:8];
      default: cur = disp_q[15:12];
    endcase
    // A digit is a leading zero only if it and every higher digit are zero; a non-BCD code counts as non-zero.
    unique case (idx_q)
      2'd3:    blank = zero[3];
      2'd2:    blank = zero[3] & zero[2];
      2'd1:    blank = zero[3] & zero[2] & zero[1];
      default: blank = 1'b0;
    endcase
    blank = blank & bus.blank_leading;
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (primed_q && !blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(cur);
      dp_d  = ~DP_MASK[idx_q];
    end
  end

  // State and output registers; synchronous reset blanks the display.
  always_ff @(posedge clk) begin
    if (init_regs) begin
      dwell_q  <= '0;
      idx_q    <= 2'd0;
      disp_q   <= 16'h0000;
      primed_q <= 1'b0;
      an_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
      dp_q     <= 1'b1;
    end else begin
      dwell_q  <= dwell_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      primed_q <= primed_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display (DWELL = 5). Expected display states are queued
// with each stimulus step and popped one per clock. Each popped value is compared
// against the main DUT and a DP_MASK=4'b0010 twin.
module tb_seg7_scan_display;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000,
                         S8 = 7'b0000000, S9 = 7'b0010000, SD = 7'b0111111,
                         DARK = 7'b1111111;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       dp2;
  } obs_t;

  logic        clk = 1'b0;
  logic        init_regs;
  logic [15:0] digits;
  logic        frz, bl;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  obs_t        exp_q[$];

  seg7_scan_display_if bus ();
  seg7_scan_display_if bus_dp ();

  assign bus.digits_bcd    = digits;
  assign bus.freeze        = frz;
  assign bus.blank_leading = bl;
  assign bus_dp.digits_bcd    = digits;
  assign bus_dp.freeze        = frz;
  assign bus_dp.blank_leading = bl;

  seg7_scan_display #(.CLK_FREQ(100), .REFRESH_HZ(5), .DP_MASK(4'b0000)) u_dut (
    .clk(clk), .init_regs(init_regs), .bus(bus));
  seg7_scan_display #(.CLK_FREQ(100), .REFRESH_HZ(5), .DP_MASK(4'b0010)) u_dut_dp (
    .clk(clk), .init_regs(init_regs), .bus(bus_dp));

  always #5 clk = ~clk;

  task automatic push_dark(input int n);
    obs_t e;
    e = '{an: 4'b1111, seg: DARK, dp: 1'b1, dp2: 1'b1};
    for (int k = 0; k < n; k++) exp_q.push_back(e);
  endtask

  // n cycles of digit i showing s (or blanked)
  task automatic push_digit(input int i, input logic [6:0] s, input logic blk, input int n);
    obs_t e;
    if (blk) begin
      e = '{an: 4'b1111, seg: DARK, dp: 1'b1, dp2: 1'b1};
    end else begin
      e.an    = 4'b1111;
      e.an[i] = 1'b0;
      e.seg   = s;
      e.dp    = 1'b1;
      e.dp2   = (i == 1) ? 1'b0 : 1'b1;
    end
    for (int k = 0; k < n; k++) exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] blk);
    push_digit(0, s0, blk[0], 5);
    push_digit(1, s1, blk[1], 5);
    push_digit(2, s2, blk[2], 5);
    push_digit(3, s3, blk[3], 5);
  endtask

  task automatic run(input int n, input string tag);
    obs_t e, o;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL %s cyc=%0d: scoreboard empty, observed an=%b seg=%b, required a queued entry",
               tag, cyc, bus.an, bus.seg);
      end else begin
        e = exp_q.pop_front();
        o = '{an: bus.an, seg: bus.seg, dp: bus.dp, dp2: bus_dp.dp};
        assert (o === e) else begin
          errors++;
          $error("FAIL %s cyc=%0d: observed an=%b seg=%b dp=%b dp2=%b, required an=%b seg=%b dp=%b dp2=%b",
                 tag, cyc, o.an, o.seg, o.dp, o.dp2, e.an, e.seg, e.dp, e.dp2);
        end
      end
    end
  endtask

  initial begin
    init_regs = 1'b1;
    digits    = 16'h1234;
    frz       = 1'b0;
    bl        = 1'b0;

    // Reset held for three edges: all dark.
    push_dark(3);
    run(3, "reset");

    // Release: dark on the first edge, digit 0 from the second edge.
    init_regs = 1'b0;
    digits    = 16'h0017;
    push_dark(1);
    push_digit(0, S7, 1'b0, 4);
    push_digit(1, S1, 1'b0, 5);
    push_digit(2, S0, 1'b0, 5);
    push_digit(3, S0, 1'b0, 5);
    run(20, "first_frame");

    // Full scan, no blanking.
    push_frame(S7, S1, S0, S0, 4'b0000);
    run(20, "scan_0017");

    // Blanking: 0017, then 0000, then 0A05. Each input change shows up one frame later.
    bl     = 1'b1;
    digits = 16'h0000;
    push_frame(S7, S1, DARK, DARK, 4'b1100);
    run(20, "blank_0017");
    digits = 16'h0A05;
    push_frame(S0, S0, S0, S0, 4'b1110);
    run(20, "blank_0000");
    digits = 16'h0019;
    push_frame(S5, S0, SD, S0, 4'b1000);
    run(20, "blank_0a05");

    // Tear-free: change the input during the digit-1 slot.
    bl = 1'b0;
    push_frame(S9, S1, S0, S0, 4'b0000);
    run(7, "tear_pre");
    digits = 16'h0020;
    run(13, "tear_rest");
    digits = 16'h0017;
    push_frame(S0, S2, S0, S0, 4'b0000);
    run(20, "tear_next");

    // Freeze with a new input: 0017 held for three frames, then released.
    frz    = 1'b1;
    digits = 16'h0018;
    push_frame(S7, S1, S0, S0, 4'b0000);
    push_frame(S7, S1, S0, S0, 4'b0000);
    push_frame(S7, S1, S0, S0, 4'b0000);
    run(60, "freeze_hold");
    frz = 1'b0;
    push_frame(S7, S1, S0, S0, 4'b0000);
    run(20, "freeze_release");
    push_frame(S8, S1, S0, S0, 4'b0000);
    run(20, "unfreeze");

    // Reset during the digit-2 slot, then restart with a fresh snapshot.
    digits = 16'h0042;
    push_digit(0, S8, 1'b0, 5);
    push_digit(1, S1, 1'b0, 5);
    push_digit(2, S0, 1'b0, 2);
    run(12, "pre_reset");
    init_regs = 1'b1;
    push_dark(2);
    run(2, "mid_reset");
    init_regs = 1'b0;
    push_dark(1);
    push_digit(0, S2, 1'b0, 4);
    push_digit(1, S4, 1'b0, 5);
    push_digit(2, S0, 1'b0, 5);
    push_digit(3, S0, 1'b0, 5);
    run(20, "restart");
    push_frame(S2, S4, S0, S0, 4'b0000);
    run(20, "restart_frame");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
